// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite subordinate that terminates the bus in a bank of NUM_REGS 32-bit
// read/write registers. All register contents are exported to fabric.
// The read and write channels run independently. Each channel holds at most
// one transaction at a time.
`timescale 1ns/1ps
module axi4lite_reg_slave #(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          NUM_REGS    = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   input  logic [ADDR_WIDTH-1:0]    s_awaddr,
   input  logic [2:0]               s_awprot,
   input  logic                     s_wvalid,
   output logic                     s_wready,
   input  logic [31:0]              s_wdata,
   input  logic [3:0]               s_wstrb,
   output logic                     s_bvalid,
   input  logic                     s_bready,
   output logic [1:0]               s_bresp,
   input  logic                     s_arvalid,
   output logic                     s_arready,
   input  logic [ADDR_WIDTH-1:0]    s_araddr,
   input  logic [2:0]               s_arprot,
   output logic                     s_rvalid,
   input  logic                     s_rready,
   output logic [31:0]              s_rdata,
   output logic [1:0]               s_rresp,
   output logic [32*NUM_REGS-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   localparam int          IDX_W  = $clog2(NUM_REGS);
   localparam logic [0:0]  W_IDLE = 1'b0;
   localparam logic [0:0]  W_RESP = 1'b1;
   localparam logic [0:0]  R_IDLE = 1'b0;
   localparam logic [0:0]  R_RESP = 1'b1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [31:0]            r_regs [NUM_REGS];
   logic                   r_bus_en;
   logic [0:0]             r_wstate;
   logic                   r_aw_held;
   logic                   r_w_held;
   logic [ADDR_WIDTH-1:0]  r_awaddr;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wstrb;
   logic                   r_bvalid;
   logic [1:0]             r_bresp;
   logic [NUM_REGS-1:0]    r_wr_pulse;
   logic [0:0]             r_rstate;
   logic                   r_rvalid;
   logic [31:0]            r_rdata;
   logic [1:0]             r_rresp;

   logic                   w_aw_hs;
   logic                   w_w_hs;
   logic                   w_wr_go;
   logic [ADDR_WIDTH-1:0]  w_wr_addr;
   logic [31:0]            w_wr_data;
   logic [3:0]             w_wr_strb;
   logic                   w_wr_err;
   logic [IDX_W-1:0]       w_wr_idx;
   logic                   w_rd_hs;
   logic                   w_rd_err;
   logic [IDX_W-1:0]       w_rd_idx;
   logic                   w_unused;

   // Readies are built only from registered state. r_bus_en holds them low
   // during reset.
   assign s_awready = r_bus_en & (r_wstate == W_IDLE) & ~r_aw_held;
   assign s_wready  = r_bus_en & (r_wstate == W_IDLE) & ~r_w_held;
   assign s_arready = r_bus_en & (r_rstate == R_IDLE);

   assign w_aw_hs   = s_awvalid & s_awready;
   assign w_w_hs    = s_wvalid & s_wready;
   // A write fires once both address and data are present, held or arriving now.
   assign w_wr_go   = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
   assign w_wr_addr = r_aw_held ? r_awaddr : s_awaddr;
   assign w_wr_data = r_w_held ? r_wdata : s_wdata;
   assign w_wr_strb = r_w_held ? r_wstrb : s_wstrb;
   assign w_wr_err  = |w_wr_addr[ADDR_WIDTH-1:IDX_W+2];
   assign w_wr_idx  = w_wr_addr[2 +: IDX_W];

   assign w_rd_hs   = s_arvalid & s_arready;
   assign w_rd_err  = |s_araddr[ADDR_WIDTH-1:IDX_W+2];
   assign w_rd_idx  = s_araddr[2 +: IDX_W];

   // Protection bits and the byte-offset address bits carry no meaning here.
   assign w_unused  = ^{s_awprot, s_arprot, s_araddr[1:0], w_wr_addr[1:0]};

   assign s_bvalid     = r_bvalid;
   assign s_bresp      = r_bresp;
   assign s_rvalid     = r_rvalid;
   assign s_rdata      = r_rdata;
   assign s_rresp      = r_rresp;
   assign reg_wr_pulse = r_wr_pulse;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_export
         assign reg_q[32*gi +: 32] = r_regs[gi];
      end
   endgenerate

   // Ready enable: stays low while reset is held, then goes high on the first edge after release.
   always_ff @(posedge aclk) begin
      r_bus_en <= ~areset;
   end

   // Write channel: latch AW and W separately, then answer with one B beat.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wstate   <= W_IDLE;
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         case (r_wstate)
            W_IDLE: begin
               if (w_wr_go) begin
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                  r_wstate  <= W_RESP;
                  if (!w_wr_err) r_wr_pulse[w_wr_idx] <= 1'b1;
               end else begin
                  if (w_aw_hs) begin
                     r_aw_held <= 1'b1;
                     r_awaddr  <= s_awaddr;
                  end
                  if (w_w_hs) begin
                     r_w_held <= 1'b1;
                     r_wdata  <= s_wdata;
                     r_wstrb  <= s_wstrb;
                  end
               end
            end
            default: begin
               if (s_bready) begin
                  r_bvalid <= 1'b0;
                  r_wstate <= W_IDLE;
               end
            end
         endcase
      end
   end

   // Register bank: apply a byte-masked update when an in-range write fires.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VALUE;
      end else if (w_wr_go && !w_wr_err) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_wr_idx == IDX_W'(k)) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_wr_strb[b]) r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Read channel: snapshot register state on AR, then hold R until it is accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rstate <= R_IDLE;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_rd_hs) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_rd_err ? 32'h0 : r_regs[w_rd_idx];
                  r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                  r_rstate <= R_RESP;
               end
            end
            default: begin
               if (s_rready) begin
                  r_rvalid <= 1'b0;
                  r_rstate <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized bench for axi4lite_reg_slave. A plain array model of the
// register bank predicts every response, register value and write pulse.
`timescale 1ns/1ps
module tb_axi4lite_reg_slave;

   localparam int          NREGS = 8;
   localparam logic [31:0] RV    = 32'h0;

   logic                  aclk = 1'b0;
   logic                  areset;
   logic                  s_awvalid, s_awready;
   logic [31:0]           s_awaddr;
   logic [2:0]            s_awprot;
   logic                  s_wvalid, s_wready;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_bvalid, s_bready;
   logic [1:0]            s_bresp;
   logic                  s_arvalid, s_arready;
   logic [31:0]           s_araddr;
   logic [2:0]            s_arprot;
   logic                  s_rvalid, s_rready;
   logic [31:0]           s_rdata;
   logic [1:0]            s_rresp;
   logic [32*NREGS-1:0]   reg_q;
   logic [NREGS-1:0]      reg_wr_pulse;

   logic [31:0] model [NREGS];
   int n_checks = 0;
   int n_errors = 0;

   axi4lite_reg_slave #(.ADDR_WIDTH(32), .NUM_REGS(NREGS), .RESET_VALUE(RV)) dut (
      .aclk(aclk), .areset(areset),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREGS; i++) check($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], model[i]);
   endtask

   function automatic bit in_range(input logic [31:0] addr);
      return addr < 32'(4*NREGS);
   endfunction

   // Apply a write to the model. Return the expected response and pulse vector.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output logic [31:0] pulse);
      int idx;
      if (in_range(addr)) begin
         idx = int'(addr / 4);
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         resp  = 2'b00;
         pulse = 32'd1 << idx;
      end else begin
         resp  = 2'b10;
         pulse = 32'd0;
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      int cyc = 0;
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      logic [1:0]  exp_resp;
      logic [31:0] exp_pulse;
      while (!(aw_done && w_done)) begin
         @(negedge aclk);
         if (w_done && !aw_done) check("w_held_wready", 32'(s_wready), 32'd0);
         if (aw_done && !w_done) check("aw_held_awready", 32'(s_awready), 32'd0);
         s_awvalid = !aw_done && cyc >= aw_dly;
         s_awaddr  = addr;
         s_awprot  = 3'($urandom);
         s_wvalid  = !w_done && cyc >= w_dly;
         s_wdata   = data;
         s_wstrb   = strb;
         aw_hs = s_awvalid && s_awready;
         w_hs  = s_wvalid && s_wready;
         @(posedge aclk);
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
         if (cyc > 64) begin
            check("wr_timeout", 32'(cyc), 32'd64);
            break;
         end
      end
      @(negedge aclk);
      s_awvalid = 0;
      s_wvalid  = 0;
      model_write(addr, data, strb, exp_resp, exp_pulse);
      check("b_valid", 32'(s_bvalid), 32'd1);
      check("b_resp", 32'(s_bresp), 32'(exp_resp));
      check("wr_pulse", 32'(reg_wr_pulse), exp_pulse);
      check_regs("wr");
      for (int i = 0; i < b_dly; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         check("b_hold_valid", 32'(s_bvalid), 32'd1);
         check("b_hold_resp", 32'(s_bresp), 32'(exp_resp));
         check("b_hold_ready", 32'({s_awready, s_wready}), 32'd0);
         check("b_hold_pulse", 32'(reg_wr_pulse), 32'd0);
      end
      s_bready = 1;
      @(posedge aclk);
      @(negedge aclk);
      s_bready = 0;
      check("b_done_valid", 32'(s_bvalid), 32'd0);
      check("b_done_pulse", 32'(reg_wr_pulse), 32'd0);
      $display("WR addr=%h data=%h strb=%h resp=%0d", addr, data, strb, exp_resp);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      int cyc = 0;
      bit hs = 0;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      while (!hs) begin
         @(negedge aclk);
         s_arvalid = cyc >= ar_dly;
         s_araddr  = addr;
         s_arprot  = 3'($urandom);
         hs = s_arvalid && s_arready;
         @(posedge aclk);
         cyc++;
         if (cyc > 64) begin
            check("rd_timeout", 32'(cyc), 32'd64);
            break;
         end
      end
      exp_data = in_range(addr) ? model[int'(addr / 4)] : 32'h0;
      exp_resp = in_range(addr) ? 2'b00 : 2'b10;
      @(negedge aclk);
      s_arvalid = 0;
      check("r_valid", 32'(s_rvalid), 32'd1);
      check("r_data", s_rdata, exp_data);
      check("r_resp", 32'(s_rresp), 32'(exp_resp));
      check("r_arready_busy", 32'(s_arready), 32'd0);
      for (int i = 0; i < r_dly; i++) begin
         @(posedge aclk);
         @(negedge aclk);
         check("r_hold_valid", 32'(s_rvalid), 32'd1);
         check("r_hold_data", s_rdata, exp_data);
         check("r_hold_resp", 32'(s_rresp), 32'(exp_resp));
      end
      s_rready = 1;
      @(posedge aclk);
      @(negedge aclk);
      s_rready = 0;
      check("r_done_valid", 32'(s_rvalid), 32'd0);
      check("r_done_arready", 32'(s_arready), 32'd1);
      $display("RD addr=%h data=%h resp=%0d", addr, exp_data, exp_resp);
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      if (r < 8)  return 32'($urandom_range(0, NREGS-1) * 4 + $urandom_range(0, 3));
      if (r == 8) return 32'(4*NREGS + $urandom_range(0, 63));
      return $urandom | 32'h0000_1000;
   endfunction

   initial begin
      logic [31:0] old_val;
      logic [1:0]  e_resp;
      logic [31:0] e_pulse;
      areset = 1;
      {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '0;
      s_awaddr = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0; s_arprot = '0;
      for (int i = 0; i < NREGS; i++) model[i] = RV;

      // Reset state
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check("rst_ready_low", 32'({s_awready, s_wready, s_arready}), 32'd0);
      check("rst_valid_low", 32'({s_bvalid, s_rvalid}), 32'd0);
      areset = 0;
      @(posedge aclk);
      @(negedge aclk);
      check("rst_ready_high", 32'({s_awready, s_wready, s_arready}), 32'd7);
      check("rst_outputs", {s_bvalid, s_rvalid, s_bresp, s_rresp}, 32'd0);
      check("rst_rdata", s_rdata, 32'd0);
      check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
      check_regs("rst");

      // A read of reg1 captured on the same edge as a write to reg1 returns the old value
      @(negedge aclk);
      s_awvalid = 1; s_awaddr = 32'h4; s_wvalid = 1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
      s_arvalid = 1; s_araddr = 32'h4;
      old_val = model[1];
      @(posedge aclk);
      @(negedge aclk);
      {s_awvalid, s_wvalid, s_arvalid} = '0;
      model_write(32'h4, 32'hA5A5A5A5, 4'hF, e_resp, e_pulse);
      check("sim_rvalid", 32'(s_rvalid), 32'd1);
      check("sim_rdata_old", s_rdata, old_val);
      check("sim_bvalid", 32'(s_bvalid), 32'd1);
      check("sim_pulse", 32'(reg_wr_pulse), e_pulse);
      check_regs("sim");
      s_bready = 1; s_rready = 1;
      @(posedge aclk);
      @(negedge aclk);
      s_bready = 0; s_rready = 0;
      $display("RW same-edge reg1 rdata=%h", old_val);
      do_read(32'h4, 0, 0);

      // Same-cycle AW/W, then read back
      do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check("t2_reg1", reg_q[63:32], 32'hDEADBEEF);
      do_read(32'h4, 0, 0);

      // W three cycles ahead of AW, partial strobe, B held off for 5 cycles
      do_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 5);
      check("t3_reg2", reg_q[95:64], 32'h00220044);

      // Out-of-range write and read
      do_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 1, 1);
      do_read(32'h20, 0, 2);

      // Reset while both B and R are pending
      @(negedge aclk);
      s_awvalid = 1; s_awaddr = 32'h0; s_wvalid = 1; s_wdata = 32'h12345678; s_wstrb = 4'hF;
      s_arvalid = 1; s_araddr = 32'h8;
      @(posedge aclk);
      @(negedge aclk);
      {s_awvalid, s_wvalid, s_arvalid} = '0;
      check("pre_rst_bvalid", 32'(s_bvalid), 32'd1);
      check("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
      areset = 1;
      @(posedge aclk);
      @(negedge aclk);
      for (int i = 0; i < NREGS; i++) model[i] = RV;
      check("mid_rst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
      check("mid_rst_pulse", 32'(reg_wr_pulse), 32'd0);
      check_regs("mid_rst");
      areset = 0;
      @(posedge aclk);
      @(negedge aclk);
      check("post_rst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
      do_write(32'hC, 32'h0BADC0DE, 4'hF, 0, 0, 0);
      do_read(32'hC, 1, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3));
         else
            do_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
